// File: rtl/jtag_tap_ctrl.sv
// IEEE 1149.1-style TAP controller: 16-state FSM, instruction register and
// BYPASS / IDCODE / USER data registers bridging a serial port to core logic.
module jtag_tap_ctrl #(
    parameter int          DEFAULT    = 32,
    parameter int          IR_W       = 4,
    parameter logic [31:0] IDCODE_VAL = 32'h1BEE_F001
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tms,
    input  logic               tdi,
    output logic               tdo,
    output logic               tdo_en,
    input  logic [DEFAULT-1:0] core_din,
    output logic [DEFAULT-1:0] core_dout,
    output logic               core_capture,
    output logic               core_update,
    output logic [IR_W-1:0]    ir,
    output logic [3:0]         tap_state
);

    typedef enum logic [3:0] {
        TLR      = 4'hF, RTI      = 4'hC,
        SEL_DR   = 4'h7, CAP_DR   = 4'h6, SH_DR  = 4'h2, EX1_DR = 4'h1,
        PAUSE_DR = 4'h3, EX2_DR   = 4'h0, UPD_DR = 4'h5,
        SEL_IR   = 4'h4, CAP_IR   = 4'hE, SH_IR  = 4'hA, EX1_IR = 4'h9,
        PAUSE_IR = 4'hB, EX2_IR   = 4'h8, UPD_IR = 4'hD
    } tap_state_t;

    localparam logic [IR_W-1:0] IR_IDCODE  = IR_W'(4'b0001);
    localparam logic [IR_W-1:0] IR_USER    = IR_W'(4'b0010);
    localparam logic [IR_W-1:0] IR_CAPTURE = IR_W'(2'b01);

    tap_state_t         state_r, next_state_s;
    logic [IR_W-1:0]    ir_r, ir_sr_r, nxt_ir_s, nxt_ir_sr_s;
    logic [31:0]        id_sr_r, nxt_id_sr_s;
    logic [DEFAULT-1:0] user_sr_r, nxt_user_sr_s, dout_r;
    logic               bp_r, nxt_bp_s;
    logic               sel_id_s, sel_user_s, tdo_next_s;
    logic               tdo_r, tdo_en_r, capture_r, update_r;

    // TAP state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= TLR;
        end else begin
            state_r <= next_state_s;
        end
    end

    // TAP next-state decode from TMS
    always_comb begin
        next_state_s = TLR;
        case (state_r)
            TLR:      next_state_s = tms ? TLR    : RTI;
            RTI:      next_state_s = tms ? SEL_DR : RTI;
            SEL_DR:   next_state_s = tms ? SEL_IR : CAP_DR;
            CAP_DR:   next_state_s = tms ? EX1_DR : SH_DR;
            SH_DR:    next_state_s = tms ? EX1_DR : SH_DR;
            EX1_DR:   next_state_s = tms ? UPD_DR : PAUSE_DR;
            PAUSE_DR: next_state_s = tms ? EX2_DR : PAUSE_DR;
            EX2_DR:   next_state_s = tms ? UPD_DR : SH_DR;
            UPD_DR:   next_state_s = tms ? SEL_DR : RTI;
            SEL_IR:   next_state_s = tms ? TLR    : CAP_IR;
            CAP_IR:   next_state_s = tms ? EX1_IR : SH_IR;
            SH_IR:    next_state_s = tms ? EX1_IR : SH_IR;
            EX1_IR:   next_state_s = tms ? UPD_IR : PAUSE_IR;
            PAUSE_IR: next_state_s = tms ? EX2_IR : PAUSE_IR;
            EX2_IR:   next_state_s = tms ? UPD_IR : SH_IR;
            UPD_IR:   next_state_s = tms ? SEL_DR : RTI;
            default:  next_state_s = TLR;
        endcase
    end

    // Instruction decode; unknown codes fall through to BYPASS
    always_comb begin
        sel_id_s   = (ir_r == IR_IDCODE);
        sel_user_s = (ir_r == IR_USER);
    end

    // Next values of IR and the data registers for the current state
    always_comb begin
        nxt_ir_s      = ir_r;
        nxt_ir_sr_s   = ir_sr_r;
        nxt_id_sr_s   = id_sr_r;
        nxt_user_sr_s = user_sr_r;
        nxt_bp_s      = bp_r;
        case (state_r)
            TLR:    nxt_ir_s    = IR_IDCODE;
            CAP_IR: nxt_ir_sr_s = IR_CAPTURE;
            SH_IR:  nxt_ir_sr_s = {tdi, ir_sr_r[IR_W-1:1]};
            UPD_IR: nxt_ir_s    = ir_sr_r;
            CAP_DR: begin
                if (sel_id_s) begin
                    nxt_id_sr_s = IDCODE_VAL;
                end else if (sel_user_s) begin
                    nxt_user_sr_s = core_din;
                end else begin
                    nxt_bp_s = 1'b0;
                end
            end
            SH_DR: begin
                if (sel_id_s) begin
                    nxt_id_sr_s = {tdi, id_sr_r[31:1]};
                end else if (sel_user_s) begin
                    nxt_user_sr_s = {tdi, user_sr_r[DEFAULT-1:1]};
                end else begin
                    nxt_bp_s = tdi;
                end
            end
            default: nxt_ir_s = ir_r;
        endcase
    end

    // TDO is precomputed from next register contents so the pin is a flop
    always_comb begin
        tdo_next_s = 1'b0;
        if (next_state_s == SH_IR) begin
            tdo_next_s = nxt_ir_sr_s[0];
        end else if (next_state_s == SH_DR) begin
            if (nxt_ir_s == IR_IDCODE) begin
                tdo_next_s = nxt_id_sr_s[0];
            end else if (nxt_ir_s == IR_USER) begin
                tdo_next_s = nxt_user_sr_s[0];
            end else begin
                tdo_next_s = nxt_bp_s;
            end
        end else begin
            tdo_next_s = 1'b0;
        end
    end

    // Register file, core handshake and registered serial outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            ir_r      <= IR_IDCODE;
            ir_sr_r   <= '0;
            id_sr_r   <= '0;
            user_sr_r <= '0;
            bp_r      <= 1'b0;
            dout_r    <= '0;
            update_r  <= 1'b0;
            capture_r <= 1'b0;
            tdo_r     <= 1'b0;
            tdo_en_r  <= 1'b0;
        end else begin
            ir_r      <= nxt_ir_s;
            ir_sr_r   <= nxt_ir_sr_s;
            id_sr_r   <= nxt_id_sr_s;
            user_sr_r <= nxt_user_sr_s;
            bp_r      <= nxt_bp_s;
            if ((state_r == UPD_DR) && sel_user_s) begin
                dout_r   <= user_sr_r;
                update_r <= 1'b1;
            end else begin
                update_r <= 1'b0;
            end
            capture_r <= (next_state_s == CAP_DR) && (nxt_ir_s == IR_USER);
            tdo_r     <= tdo_next_s;
            tdo_en_r  <= (next_state_s == SH_DR) || (next_state_s == SH_IR);
        end
    end

    assign tap_state    = state_r;
    assign ir           = ir_r;
    assign tdo          = tdo_r;
    assign tdo_en       = tdo_en_r;
    assign core_dout    = dout_r;
    assign core_update  = update_r;
    assign core_capture = capture_r;

endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// Directed and random stimulus for jtag_tap_ctrl, checked cycle by cycle
// against a table-driven TAP model with integer shift-register arithmetic.
module tb_jtag_tap_ctrl;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst, tms, tdi;
    logic         tdo, tdo_en, core_capture, core_update;
    logic [W-1:0] core_din, core_dout;
    logic [3:0]   ir, tap_state;

    jtag_tap_ctrl #(.DEFAULT(W), .IR_W(4), .IDCODE_VAL(32'h1BEE_F001)) dut (
        .clk(clk), .rst(rst), .tms(tms), .tdi(tdi), .tdo(tdo), .tdo_en(tdo_en),
        .core_din(core_din), .core_dout(core_dout), .core_capture(core_capture),
        .core_update(core_update), .ir(ir), .tap_state(tap_state)
    );

    always #5 clk = ~clk;

    // Reference model: state transition tables indexed by standard state code
    logic [3:0]  nx0 [16];
    logic [3:0]  nx1 [16];
    logic [3:0]  m_state, m_ir, m_irsr;
    logic [31:0] m_id, m_user, m_dout;
    logic        m_bp, m_upd;

    int passed = 0;
    int total  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input logic r, input logic t, input logic d);
        logic [3:0] st;
        st = m_state;
        if (r) begin
            m_state = 4'hF; m_ir = 4'd1; m_irsr = 4'd0;
            m_id = 32'd0; m_user = 32'd0; m_bp = 1'b0; m_dout = 32'd0; m_upd = 1'b0;
        end else begin
            m_upd = (st == 4'h5) && (m_ir == 4'd2);
            if (m_upd) m_dout = m_user;
            if (st == 4'hE) m_irsr = 4'd1;
            if (st == 4'hA) m_irsr = (m_irsr >> 1) | (4'(d) << 3);
            if (st == 4'hD) m_ir = m_irsr;
            if (st == 4'hF) m_ir = 4'd1;
            if (st == 4'h6) begin
                if (m_ir == 4'd1) m_id = 32'h1BEE_F001;
                else if (m_ir == 4'd2) m_user = core_din;
                else m_bp = 1'b0;
            end
            if (st == 4'h2) begin
                if (m_ir == 4'd1) m_id = (m_id >> 1) | (32'(d) << 31);
                else if (m_ir == 4'd2) m_user = (m_user >> 1) | (32'(d) << 31);
                else m_bp = d;
            end
            m_state = t ? nx1[st] : nx0[st];
        end
    endtask

    task automatic check_all();
        logic exp_tdo;
        exp_tdo = 1'b0;
        if (m_state == 4'hA) exp_tdo = m_irsr[0];
        else if (m_state == 4'h2)
            exp_tdo = (m_ir == 4'd1) ? m_id[0] : (m_ir == 4'd2) ? m_user[0] : m_bp;
        chk("tap_state", 32'(tap_state), 32'(m_state));
        chk("ir", 32'(ir), 32'(m_ir));
        chk("tdo", 32'(tdo), 32'(exp_tdo));
        chk("tdo_en", 32'(tdo_en), 32'((m_state == 4'h2) || (m_state == 4'hA)));
        chk("core_dout", core_dout, m_dout);
        chk("core_update", 32'(core_update), 32'(m_upd));
        chk("core_capture", 32'(core_capture), 32'((m_state == 4'h6) && (m_ir == 4'd2)));
    endtask

    task automatic step_r(input logic r, input logic t, input logic d);
        rst = r; tms = t; tdi = d;
        @(posedge clk);
        model_edge(r, t, d);
        #1;
        check_all();
    endtask

    task automatic step(input logic t, input logic d);
        step_r(1'b0, t, d);
    endtask

    task automatic shift(input logic [31:0] data, input int n, output logic [31:0] got);
        got = 32'd0;
        for (int i = 0; i < n; i++) begin
            got[i] = tdo;
            step((i == n - 1) ? 1'b1 : 1'b0, data[i]);
        end
    endtask

    // From RTI: load an instruction and return to RTI
    task automatic load_ir(input logic [3:0] code, output logic [31:0] got);
        step(1'b1, 1'b0); step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
        shift(32'(code), 4, got);
        step(1'b1, 1'b0); step(1'b0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] got, word;
        nx0[4'hF] = 4'hC; nx1[4'hF] = 4'hF;
        nx0[4'hC] = 4'hC; nx1[4'hC] = 4'h7;
        nx0[4'h7] = 4'h6; nx1[4'h7] = 4'h4;
        nx0[4'h4] = 4'hE; nx1[4'h4] = 4'hF;
        nx0[4'h6] = 4'h2; nx1[4'h6] = 4'h1;
        nx0[4'h2] = 4'h2; nx1[4'h2] = 4'h1;
        nx0[4'h1] = 4'h3; nx1[4'h1] = 4'h5;
        nx0[4'h3] = 4'h3; nx1[4'h3] = 4'h0;
        nx0[4'h0] = 4'h2; nx1[4'h0] = 4'h5;
        nx0[4'h5] = 4'hC; nx1[4'h5] = 4'h7;
        nx0[4'hE] = 4'hA; nx1[4'hE] = 4'h9;
        nx0[4'hA] = 4'hA; nx1[4'hA] = 4'h9;
        nx0[4'h9] = 4'hB; nx1[4'h9] = 4'hD;
        nx0[4'hB] = 4'hB; nx1[4'hB] = 4'h8;
        nx0[4'h8] = 4'hA; nx1[4'h8] = 4'hD;
        nx0[4'hD] = 4'hC; nx1[4'hD] = 4'h7;
        rst = 1'b1; tms = 1'b1; tdi = 1'b0; core_din = '0;

        // Reset, then walk into Shift-DR and escape with five TMS=1
        step_r(1'b1, 1'b1, 1'b0);
        chk("reset_state", 32'(tap_state), 32'hF);
        chk("reset_ir", 32'(ir), 32'h1);
        chk("reset_dout", core_dout, 32'h0);
        step(1'b0, 1'b0); step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
        chk("in_shdr", 32'(tap_state), 32'h2);
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
        chk("tlr_after_5", 32'(tap_state), 32'hF);

        // IDCODE read straight after reset
        step_r(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0); step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
        shift(32'h0, 32, got);
        chk("idcode_read", got, 32'h1BEE_F001);
        step(1'b1, 1'b0); step(1'b0, 1'b0);

        // USER load, capture of core status and update
        load_ir(4'b0010, got);
        chk("ir_capture_tdo", got, 32'h1);
        chk("ir_user", 32'(ir), 32'h2);
        core_din = 32'h1234_ABCD;
        step(1'b1, 1'b0); step(1'b0, 1'b0);
        chk("core_capture_hi", 32'(core_capture), 32'h1);
        step(1'b0, 1'b0);
        shift(32'hA5A5_0F0F, 32, got);
        chk("user_capture", got, 32'h1234_ABCD);
        step(1'b1, 1'b0);
        chk("no_update_in_upd", 32'(core_update), 32'h0);
        step(1'b0, 1'b0);
        chk("update_pulse", 32'(core_update), 32'h1);
        chk("user_dout", core_dout, 32'hA5A5_0F0F);
        step(1'b0, 1'b0);
        chk("update_single", 32'(core_update), 32'h0);

        // BYPASS: one-cycle delay with a leading captured 0
        load_ir(4'b1111, got);
        step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
        shift(32'b1101, 4, got);
        chk("bypass_tdo", got, 32'b1010);
        step(1'b1, 1'b0); step(1'b0, 1'b0);
        chk("bypass_no_side", core_dout, 32'hA5A5_0F0F);

        // Pause-DR in the middle of a USER shift
        load_ir(4'b0010, got);
        word = $urandom;
        core_din = $urandom;
        step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
        shift({16'd0, word[15:0]}, 16, got);
        step(1'b0, 1'b0);
        chk("in_pause", 32'(tap_state), 32'h3);
        for (int i = 0; i < 10; i++) step(1'b0, $urandom_range(0, 1));
        step(1'b1, 1'b0); step(1'b0, 1'b0);
        shift({16'd0, word[31:16]}, 16, got);
        step(1'b1, 1'b0); step(1'b0, 1'b0);
        chk("pause_dout", core_dout, word);
        chk("pause_update", 32'(core_update), 32'h1);

        // Reset in the middle of a USER shift
        step_r(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0);
        load_ir(4'b0010, got);
        step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b0, $urandom_range(0, 1));
        step_r(1'b1, 1'b0, 1'b1);
        chk("midrst_state", 32'(tap_state), 32'hF);
        chk("midrst_ir", 32'(ir), 32'h1);
        chk("midrst_dout", core_dout, 32'h0);
        chk("midrst_update", 32'(core_update), 32'h0);

        // Random TMS/TDI walk with occasional reset and core_din changes
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 7) == 0) core_din = $urandom;
            step_r(($urandom_range(0, 149) == 0) ? 1'b1 : 1'b0,
                   ($urandom_range(0, 99) < 30) ? 1'b1 : 1'b0,
                   1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
